pixel_pool_scaler: RTL and testbench

Streaming grayscale downscaler that sits between the DVP state machine and the pixel AXI4 master TX. It reduces each frame by a runtime-selectable factor of 2 or 4 in both axes, using average, max, min or decimate pooling. A single accumulating line buffer replaces per-position pixel FIFOs. Output pixels carry end-of-line and end-of-frame markers.

---
 rtl/pxl_scaler_pkg.sv | 30 +++
 rtl/pxl_line_acc_buf.sv | 27 ++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/pixel_pool_scaler.sv | 137 +++++++++++++
 tb/tb_pixel_pool_scaler.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pxl_scaler_pkg.sv
// Shared pooling modes and arithmetic helpers for the pixel pool scaler.
package pxl_scaler_pkg;

  localparam logic [1:0] POOL_AVG   = 2'd0;
  localparam logic [1:0] POOL_MAX   = 2'd1;
  localparam logic [1:0] POOL_MIN   = 2'd2;
  localparam logic [1:0] POOL_DECIM = 2'd3;

  localparam int unsigned FOLD_W = 32;

  function automatic int unsigned acc_w(input int unsigned gs_pxl_w, input int unsigned scale_max);
    return gs_pxl_w + 2 * $clog2(scale_max);
  endfunction

  // Folds one new value into a running result; used by both pooling stages.
  function automatic logic [FOLD_W-1:0] pool_fold(input logic [1:0]        mode,
                                                  input logic [FOLD_W-1:0] acc,
                                                  input logic [FOLD_W-1:0] val);
    logic [FOLD_W-1:0] res;
    res = acc;
    unique case (mode)
      POOL_AVG:   res = acc + val;
      POOL_MAX:   res = (val > acc) ? val : acc;
      POOL_MIN:   res = (val < acc) ? val : acc;
      POOL_DECIM: res = acc;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pxl_line_acc_buf.sv
// Line of partial vertical pooling results, one entry per output column.
module pxl_line_acc_buf #(
  parameter int unsigned  COL_NUM = 640,
  parameter int unsigned  ACC_W   = 12,
  localparam int unsigned DEPTH   = COL_NUM / 2,
  localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ACC_W-1:0]  i_wdata,
  output logic [ACC_W-1:0]  o_rdata
);
  logic [ACC_W-1:0] r_line [DEPTH];

  assign o_rdata = r_line[i_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_line[i] <= '0;
    end else if (i_we) begin
      r_line[i_addr] <= i_wdata;
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO; FIFO_TYPE=1 is first-word fall-through, 0 is registered read.
module sync_fifo #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned FIFO_TYPE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_full,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_wr;
  logic              w_rd;

  assign o_full  = (r_cnt == CNT_W'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_wr    = i_wr_en & ~o_full;
  assign w_rd    = i_rd_en & ~o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= i_wr_data;
        r_wptr <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
      end
      if (w_rd) r_rptr <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);
      if (w_wr && !w_rd)      r_cnt <= r_cnt + CNT_W'(1);
      else if (!w_wr && w_rd) r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  generate
    if (FIFO_TYPE == 1) begin : g_fwft
      assign o_rd_data = r_mem[r_rptr];
    end else begin : g_reg
      logic [DATA_W-1:0] r_rd_data;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_rd_data <= '0;
        else if (w_rd) r_rd_data <= r_mem[r_rptr];
      end
      assign o_rd_data = r_rd_data;
    end
  endgenerate

endmodule

// File: rtl/pixel_pool_scaler.sv
// Streaming grayscale 2x/4x pooling downscaler with eol/eof-tagged output FIFO.
module pixel_pool_scaler
  import pxl_scaler_pkg::*;
#(
  parameter int unsigned GS_PXL_W  = 8,
  parameter int unsigned COL_NUM   = 640,
  parameter int unsigned ROW_NUM   = 480,
  parameter int unsigned SCALE_MAX = 4,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          cfg_scale_i,
  input  logic [1:0]          cfg_mode_i,
  input  logic [GS_PXL_W-1:0] dsm_pxl_i,
  input  logic                dsm_pxl_vld_i,
  input  logic                dsm_sof_i,
  output logic                dsm_pxl_rdy_o,
  input  logic                pat_rdy_i,
  output logic [GS_PXL_W-1:0] pat_pxl_o,
  output logic                pat_pxl_vld_o,
  output logic                pat_eol_o,
  output logic                pat_eof_o
);
  localparam int unsigned ACC_W = acc_w(GS_PXL_W, SCALE_MAX);
  localparam int unsigned COL_W = $clog2(COL_NUM);
  localparam int unsigned ROW_W = $clog2(ROW_NUM);
  localparam int unsigned OX_W  = $clog2(COL_NUM / 2);
  localparam int unsigned OUT_W = GS_PXL_W + 2;

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [1:0]       r_scale;
  logic [1:0]       r_mode;
  logic [ACC_W-1:0] r_hacc;

  logic             w_at_start, w_in_hs, w_push, w_pop, w_lb_we;
  logic             w_first_bx, w_last_bx, w_first_by, w_last_by, w_complete;
  logic             w_eol, w_eof, w_fifo_full, w_fifo_empty;
  logic [1:0]       w_cfg_scale, w_scale, w_mode;
  logic [2:0]       w_smask;
  logic [COL_W-1:0] w_col, w_bx, w_ox_full;
  logic [ROW_W-1:0] w_row, w_by;
  logic [OX_W-1:0]  w_ox;
  logic [ACC_W-1:0] w_pix_ext, w_hres, w_vres, w_avg, w_lb_rdata;
  logic [GS_PXL_W-1:0] w_out_pix;
  logic [OUT_W-1:0] w_fifo_rdata;

  // The pixel that opens a frame must be pooled with the incoming config, so
  // config and position bypass the registers there; neither depends on the handshake.
  always_comb begin
    w_at_start  = dsm_sof_i | ((r_col == '0) && (r_row == '0));
    w_cfg_scale = (SCALE_MAX == 4 && cfg_scale_i == 2'd2) ? 2'd2 : 2'd1;
    w_scale     = w_at_start ? w_cfg_scale : r_scale;
    w_mode      = w_at_start ? cfg_mode_i : r_mode;
    w_col       = dsm_sof_i ? '0 : r_col;
    w_row       = dsm_sof_i ? '0 : r_row;
    w_smask     = (3'd1 << w_scale) - 3'd1;
    w_bx        = w_col & COL_W'(w_smask);
    w_by        = w_row & ROW_W'(w_smask);
    w_first_bx  = (w_bx == '0);
    w_last_bx   = (w_bx == COL_W'(w_smask));
    w_first_by  = (w_by == '0);
    w_last_by   = (w_by == ROW_W'(w_smask));
    w_complete  = w_last_bx & w_last_by;
    w_ox_full   = w_col >> w_scale;
    w_ox        = OX_W'(w_ox_full);
    w_pix_ext   = ACC_W'(dsm_pxl_i);
    w_hres      = w_first_bx ? w_pix_ext
                : ACC_W'(pool_fold(w_mode, FOLD_W'(r_hacc), FOLD_W'(w_pix_ext)));
    w_vres      = w_first_by ? w_hres
                : ACC_W'(pool_fold(w_mode, FOLD_W'(w_lb_rdata), FOLD_W'(w_hres)));
    w_avg       = w_vres >> {w_scale, 1'b0};
    w_out_pix   = (w_mode == POOL_AVG) ? GS_PXL_W'(w_avg) : GS_PXL_W'(w_vres);
    w_eol       = (w_ox_full == COL_W'((COL_NUM >> w_scale) - 1));
    w_eof       = w_eol & (w_row == ROW_W'(ROW_NUM - 1));
  end

  assign dsm_pxl_rdy_o = ~(w_complete & w_fifo_full);
  assign w_in_hs       = dsm_pxl_vld_i & dsm_pxl_rdy_o;
  assign w_push        = w_in_hs & w_complete;
  assign w_lb_we       = w_in_hs & w_last_bx;
  assign pat_pxl_vld_o = ~w_fifo_empty;
  assign w_pop         = pat_pxl_vld_o & pat_rdy_i;
  assign {pat_eof_o, pat_eol_o, pat_pxl_o} = w_fifo_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col   <= '0;
      r_row   <= '0;
      r_scale <= 2'd1;
      r_mode  <= POOL_AVG;
      r_hacc  <= '0;
    end else if (w_in_hs) begin
      r_hacc <= w_hres;
      if (w_at_start) begin
        r_scale <= w_scale;
        r_mode  <= w_mode;
      end
      if (w_col == COL_W'(COL_NUM - 1)) begin
        r_col <= '0;
        r_row <= (w_row == ROW_W'(ROW_NUM - 1)) ? '0 : w_row + ROW_W'(1);
      end else begin
        r_col <= w_col + COL_W'(1);
        r_row <= w_row;
      end
    end
  end

  pxl_line_acc_buf #(
    .COL_NUM (COL_NUM),
    .ACC_W   (ACC_W)
  ) u_line_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_lb_we),
    .i_addr  (w_ox),
    .i_wdata (w_vres),
    .o_rdata (w_lb_rdata)
  );

  sync_fifo #(
    .DATA_W    (OUT_W),
    .DEPTH     (OUT_DEPTH),
    .FIFO_TYPE (1)
  ) u_out_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_push),
    .i_wr_data ({w_eof, w_eol, w_out_pix}),
    .o_full    (w_fifo_full),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_rdata),
    .o_empty   (w_fifo_empty)
  );

endmodule

// File: tb/tb_pixel_pool_scaler.sv
// Scoreboard bench for pixel_pool_scaler on an 8x8 frame.
module tb_pixel_pool_scaler;
  import pxl_scaler_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] cfg_scale_i = 2'd1;
  logic [1:0] cfg_mode_i = POOL_AVG;
  logic [7:0] dsm_pxl_i = '0;
  logic       dsm_pxl_vld_i = 1'b0;
  logic       dsm_sof_i = 1'b0;
  logic       dsm_pxl_rdy_o;
  logic       pat_rdy_i = 1'b1;
  logic [7:0] pat_pxl_o;
  logic       pat_pxl_vld_o;
  logic       pat_eol_o;
  logic       pat_eof_o;

  always #5 clk = ~clk;

  pixel_pool_scaler #(
    .GS_PXL_W  (8),
    .COL_NUM   (8),
    .ROW_NUM   (8),
    .SCALE_MAX (4),
    .OUT_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_scale_i   (cfg_scale_i),
    .cfg_mode_i    (cfg_mode_i),
    .dsm_pxl_i     (dsm_pxl_i),
    .dsm_pxl_vld_i (dsm_pxl_vld_i),
    .dsm_sof_i     (dsm_sof_i),
    .dsm_pxl_rdy_o (dsm_pxl_rdy_o),
    .pat_rdy_i     (pat_rdy_i),
    .pat_pxl_o     (pat_pxl_o),
    .pat_pxl_vld_o (pat_pxl_vld_o),
    .pat_eol_o     (pat_eol_o),
    .pat_eof_o     (pat_eof_o)
  );

  typedef struct packed {
    logic [7:0] pix;
    logic       eol;
    logic       eof;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   first_stall = -1;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Kinds: 0 ramp, 1 all 255, 2 all 1 with a 4 at (0,0), 3 tiled {10,200,3,50}
  function automatic logic [7:0] pix_of(input int kind, input int c, input int r);
    case (kind)
      0:       return 8'(c + 8 * r);
      1:       return 8'd255;
      2:       return (c == 0 && r == 0) ? 8'd4 : 8'd1;
      default: return (r % 2 == 0) ? ((c % 2 == 0) ? 8'd10 : 8'd200)
                                   : ((c % 2 == 0) ? 8'd3  : 8'd50);
    endcase
  endfunction

  task automatic push_exp(input int pix, input bit eol, input bit eof);
    exp_t e;
    e.pix = 8'(pix);
    e.eol = eol;
    e.eof = eof;
    exp_q.push_back(e);
  endtask

  task automatic exp_frame(input int kind, input int scale, input logic [1:0] mode);
    int n, v;
    n = 8 >> scale;
    for (int oy = 0; oy < n; oy++)
      for (int ox = 0; ox < n; ox++) begin
        case (kind)
          0:       v = 2 * ox + 16 * oy + 4;
          1:       v = 255;
          2:       v = 1;
          default: v = (mode == POOL_MAX) ? 200 : (mode == POOL_MIN) ? 3 : 10;
        endcase
        push_exp(v, ox == n - 1, (ox == n - 1) && (oy == n - 1));
      end
  endtask

  task automatic drive_pix(input logic [7:0] p, input bit sof, input int idx);
    dsm_pxl_i     = p;
    dsm_sof_i     = sof;
    dsm_pxl_vld_i = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (dsm_pxl_rdy_o) break;
      if (first_stall < 0) first_stall = idx;
      if (t >= 200) begin
        n_vec++;
        n_err++;
        $display("FAIL hs_timeout: pixel %0d not accepted, rdy=%0d, expected 1", idx, dsm_pxl_rdy_o);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_range(input int kind, input int from, input int upto, input bit sof_first);
    for (int i = from; i <= upto; i++)
      drive_pix(pix_of(kind, i % 8, i / 8), sof_first && (i == from), i);
    dsm_pxl_vld_i = 1'b0;
    dsm_sof_i     = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !pat_pxl_vld_o) break;
    end
    check(name, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n && pat_pxl_vld_o && pat_rdy_i) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_out: got pix %0d, expected no output", pat_pxl_o);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_pix", int'(pat_pxl_o), int'(mon_e.pix));
          check("out_eol", int'(pat_eol_o), int'(mon_e.eol));
          check("out_eof", int'(pat_eof_o), int'(mon_e.eof));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", int'(dsm_pxl_rdy_o), 1);
    check("rst_vld", int'(pat_pxl_vld_o), 0);
    check("rst_pix", int'(pat_pxl_o), 0);
    check("rst_eol", int'(pat_eol_o), 0);
    check("rst_eof", int'(pat_eof_o), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_vld", int'(pat_pxl_vld_o), 0);

    // AVG 2x2 on ramp
    cfg_scale_i = 2'd1;
    cfg_mode_i  = POOL_AVG;
    exp_frame(0, 1, POOL_AVG);
    drive_range(0, 0, 63, 1'b1);
    drain("drain_avg1");

    // AVG 4x4 saturation and truncation
    cfg_scale_i = 2'd2;
    exp_frame(1, 2, POOL_AVG);
    drive_range(1, 0, 63, 1'b1);
    drain("drain_avg2_sat");
    exp_frame(2, 2, POOL_AVG);
    drive_range(2, 0, 63, 1'b1);
    drain("drain_avg2_trunc");

    // MAX with a mid-frame mode change, then MIN and DECIM
    cfg_scale_i = 2'd1;
    cfg_mode_i  = POOL_MAX;
    exp_frame(3, 1, POOL_MAX);
    drive_range(3, 0, 7, 1'b1);
    cfg_mode_i = POOL_MIN;
    drive_range(3, 8, 63, 1'b0);
    drain("drain_max");
    exp_frame(3, 1, POOL_MIN);
    drive_range(3, 0, 63, 1'b1);
    drain("drain_min");
    cfg_mode_i = POOL_DECIM;
    exp_frame(3, 1, POOL_DECIM);
    drive_range(3, 0, 63, 1'b1);
    drain("drain_decim");

    // Backpressure: downstream stalled 40 cycles
    cfg_mode_i  = POOL_AVG;
    first_stall = -1;
    exp_frame(0, 1, POOL_AVG);
    fork
      begin
        pat_rdy_i = 1'b0;
        repeat (40) @(posedge clk);
        #1 pat_rdy_i = 1'b1;
      end
      drive_range(0, 0, 63, 1'b1);
    join
    check("stall_idx", first_stall, 25);
    drain("drain_bp");

    // SOF resync at row 3, column 5
    push_exp(4, 1'b0, 1'b0);
    push_exp(6, 1'b0, 1'b0);
    push_exp(8, 1'b0, 1'b0);
    push_exp(10, 1'b1, 1'b0);
    push_exp(20, 1'b0, 1'b0);
    push_exp(22, 1'b0, 1'b0);
    drive_range(0, 0, 28, 1'b1);
    exp_frame(0, 1, POOL_AVG);
    drive_range(0, 0, 63, 1'b1);
    exp_frame(0, 1, POOL_AVG);
    drive_range(0, 0, 63, 1'b0);
    drain("drain_sof");

    // Reset mid-frame with two outputs pending
    pat_rdy_i = 1'b0;
    drive_range(0, 0, 11, 1'b1);
    @(negedge clk);
    check("pend_vld", int'(pat_pxl_vld_o), 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_vld", int'(pat_pxl_vld_o), 0);
    check("mid_rst_pix", int'(pat_pxl_o), 0);
    check("mid_rst_rdy", int'(dsm_pxl_rdy_o), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_vld", int'(pat_pxl_vld_o), 0);
    pat_rdy_i = 1'b1;
    @(posedge clk);
    #1;
    exp_frame(0, 1, POOL_AVG);
    drive_range(0, 0, 63, 1'b1);
    drain("drain_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
